serial_cmp_sched: RTL and testbench

//  Shares one external 1-bit chainable comparator cell between two requesters.

---
 rtl/serial_cmp_sched_if.sv | 35 +++
 rtl/serial_cmp_sched.sv | 130 +++++++++++++
 tb/tb_serial_cmp_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_cmp_sched_if.sv
// Request/result bundle for serial_cmp_sched.
// Ports:
//   req0_valid/req0_ready/req0_a/req0_b - requester 0 operand pair handshake
//   req1_valid/req1_ready/req1_a/req1_b - requester 1 operand pair handshake
//   res_valid/res_ready                 - result handshake
//   res_gt/res_eq/res_lt/res_id         - compare outcome and owning requester
// The slave modport is the scheduler; the master modport is the requester/consumer side.
interface serial_cmp_sched_if #(
    parameter int WIDTH = 8
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             res_valid;
    logic             res_ready;
    logic             res_gt;
    logic             res_eq;
    logic             res_lt;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_gt, res_eq, res_lt, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_gt, res_eq, res_lt, res_id
    );
endinterface

// File: rtl/serial_cmp_sched.sv
// Shares one external 1-bit chainable comparator cell between two requesters.
// The cell computes cell_w = (cell_a ^ cell_b) ? cell_b : cell_in, i.e. a running "B > A"
// flag. Requests are round-robin arbitrated, operands captured, then walked LSB->MSB through
// the cell, holding each bit SETTLE cycles. The result is returned on a valid/ready port.
// Ports:
//   clk, rst_n              - clock (rising edge), asynchronous active-low reset
//   bus (slave modport)     - two request handshakes and the result handshake
//   cell_a, cell_b, cell_in - bit pair and chain input driven to the shared cell
//   cell_w                  - cell output, sampled on the last settle cycle of each bit
module serial_cmp_sched #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_cmp_sched_if.slave   bus,
    output logic                cell_a,
    output logic                cell_b,
    output logic                cell_in,
    input  logic                cell_w
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic             rr_ptr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_id;
    logic [CNT_W-1:0] bit_cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             acc;
    logic             eq_acc;

    logic in_idle;
    logic in_run;
    logic in_done;
    logic grant_any;
    logic grant_id;
    logic bit_a;
    logic bit_b;
    logic last_bit;
    logic last_settle;
    logic swap;

    always_comb begin
        // Gating with rst_n keeps the ready outputs low while reset is held.
        in_idle     = (state == ST_IDLE) && rst_n;
        in_run      = (state == ST_RUN);
        in_done     = (state == ST_DONE);
        grant_any   = in_idle && (bus.req0_valid || bus.req1_valid);
        grant_id    = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
        bit_a       = op_a[bit_cnt];
        bit_b       = op_b[bit_cnt];
        last_bit    = (bit_cnt == CNT_W'(WIDTH - 1));
        last_settle = (settle_cnt == SET_W'(SETTLE - 1));
        // A set sign bit makes a value smaller, so the MSB pair is fed reversed.
        swap        = SIGNED && last_bit;
    end

    always_comb begin
        bus.req0_ready = grant_any && !grant_id;
        bus.req1_ready = grant_any && grant_id;

        cell_a  = in_run && (swap ? bit_b : bit_a);
        cell_b  = in_run && (swap ? bit_a : bit_b);
        cell_in = in_run && acc;

        bus.res_valid = in_done;
        bus.res_eq    = in_done && eq_acc;
        bus.res_lt    = in_done && acc && !eq_acc;
        bus.res_gt    = in_done && !acc && !eq_acc;
        bus.res_id    = in_done && op_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            bit_cnt    <= '0;
            settle_cnt <= '0;
            acc        <= 1'b0;
            eq_acc     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        op_a       <= grant_id ? bus.req1_a : bus.req0_a;
                        op_b       <= grant_id ? bus.req1_b : bus.req0_b;
                        op_id      <= grant_id;
                        rr_ptr     <= !grant_id;
                        acc        <= 1'b0;
                        eq_acc     <= 1'b1;
                        bit_cnt    <= '0;
                        settle_cnt <= '0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_settle) begin
                        settle_cnt <= '0;
                        acc        <= cell_w;
                        eq_acc     <= eq_acc && !(bit_a ^ bit_b);
                        if (last_bit) begin
                            state <= ST_DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_cmp_sched.sv
// Directed bench for serial_cmp_sched. Three instances cover the parameter sets:
//   dsel 0: SETTLE=1 unsigned, dsel 1: SETTLE=1 signed, dsel 2: SETTLE=3 unsigned.
// Stimulus is shared and steered to the selected instance; its outputs are muxed back.
module tb_serial_cmp_sched;
    logic       clk;
    logic       rst_n;
    logic [1:0] dsel;
    logic       v0, v1, rdy;
    logic [7:0] a0, b0, a1, b1;

    int checks;
    int errors;

    serial_cmp_sched_if #(.WIDTH(8)) bus0 ();
    serial_cmp_sched_if #(.WIDTH(8)) bus1 ();
    serial_cmp_sched_if #(.WIDTH(8)) bus2 ();

    logic ca0, cb0, ci0, cw0;
    logic ca1, cb1, ci1, cw1;
    logic ca2, cb2, ci2, cw2;

    // Behavioural comparator cells.
    assign cw0 = (ca0 ^ cb0) ? cb0 : ci0;
    assign cw1 = (ca1 ^ cb1) ? cb1 : ci1;
    assign cw2 = (ca2 ^ cb2) ? cb2 : ci2;

    assign bus0.req0_valid = v0 && (dsel == 2'd0);
    assign bus0.req1_valid = v1 && (dsel == 2'd0);
    assign bus1.req0_valid = v0 && (dsel == 2'd1);
    assign bus1.req1_valid = v1 && (dsel == 2'd1);
    assign bus2.req0_valid = v0 && (dsel == 2'd2);
    assign bus2.req1_valid = v1 && (dsel == 2'd2);
    assign bus0.req0_a = a0;  assign bus0.req0_b = b0;
    assign bus0.req1_a = a1;  assign bus0.req1_b = b1;
    assign bus1.req0_a = a0;  assign bus1.req0_b = b0;
    assign bus1.req1_a = a1;  assign bus1.req1_b = b1;
    assign bus2.req0_a = a0;  assign bus2.req0_b = b0;
    assign bus2.req1_a = a1;  assign bus2.req1_b = b1;
    assign bus0.res_ready = rdy;
    assign bus1.res_ready = rdy;
    assign bus2.res_ready = rdy;

    serial_cmp_sched #(.WIDTH(8), .SETTLE(1), .SIGNED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .cell_a(ca0), .cell_b(cb0), .cell_in(ci0), .cell_w(cw0)
    );
    serial_cmp_sched #(.WIDTH(8), .SETTLE(1), .SIGNED(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .cell_a(ca1), .cell_b(cb1), .cell_in(ci1), .cell_w(cw1)
    );
    serial_cmp_sched #(.WIDTH(8), .SETTLE(3), .SIGNED(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
        .cell_a(ca2), .cell_b(cb2), .cell_in(ci2), .cell_w(cw2)
    );

    logic o_r0, o_r1, o_rv, o_gt, o_eq, o_lt, o_id, o_ca, o_cb, o_ci;

    always_comb begin
        o_r0 = bus0.req0_ready; o_r1 = bus0.req1_ready; o_rv = bus0.res_valid;
        o_gt = bus0.res_gt; o_eq = bus0.res_eq; o_lt = bus0.res_lt; o_id = bus0.res_id;
        o_ca = ca0; o_cb = cb0; o_ci = ci0;
        case (dsel)
            2'd1: begin
                o_r0 = bus1.req0_ready; o_r1 = bus1.req1_ready; o_rv = bus1.res_valid;
                o_gt = bus1.res_gt; o_eq = bus1.res_eq; o_lt = bus1.res_lt; o_id = bus1.res_id;
                o_ca = ca1; o_cb = cb1; o_ci = ci1;
            end
            2'd2: begin
                o_r0 = bus2.req0_ready; o_r1 = bus2.req1_ready; o_rv = bus2.res_valid;
                o_gt = bus2.res_gt; o_eq = bus2.res_eq; o_lt = bus2.res_lt; o_id = bus2.res_id;
                o_ca = ca2; o_cb = cb2; o_ci = ci2;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full transaction on the selected instance. exp is {gt, eq, lt}; exp_lat counts
    // edges with the accept edge as edge 1.
    task automatic run_op(input logic sel, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] exp, input int exp_lat, input string tag);
        int   lat, bad, bi, s;
        logic sgn, m_acc, ea, eb, t;
        s   = (dsel == 2'd2) ? 3 : 1;
        sgn = (dsel == 2'd1);
        @(negedge clk);
        if (sel) begin v1 = 1'b1; a1 = a; b1 = b; end
        else     begin v0 = 1'b1; a0 = a; b0 = b; end
        #1;
        check({tag, "_ready"}, {o_r0, o_r1}, sel ? 2'b01 : 2'b10);
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b0;
        a0 = ~a; b0 = 8'h00; a1 = ~a; b1 = 8'h00;
        lat = 1; bad = 0; m_acc = 1'b0;
        while (!o_rv && lat < 100) begin
            bi = (lat - 1) / s;
            if (bi < 8) begin
                ea = a[bi]; eb = b[bi];
                if (sgn && bi == 7) begin t = ea; ea = eb; eb = t; end
                if ({o_ca, o_cb, o_ci} !== {ea, eb, m_acc}) bad++;
                if ((lat - 1) % s == s - 1) m_acc = (ea ^ eb) ? eb : m_acc;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_cell"}, bad, 0);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, {o_gt, o_eq, o_lt}, exp);
        check({tag, "_id"}, o_id, sel);
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        check({tag, "_idle"}, {o_rv, o_ca, o_cb, o_ci}, 4'b0000);
    endtask

    initial begin
        int lat, bad;
        checks = 0; errors = 0;
        dsel = 2'd0; rdy = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        a0 = 8'h10; b0 = 8'h20; a1 = 8'h30; b1 = 8'h20;
        rst_n = 1'b0;
        #12;
        check("reset_outs", {o_r0, o_r1, o_rv, o_gt, o_eq, o_lt, o_id, o_ca, o_cb, o_ci}, 0);

        // Round robin: both valid from reset, consumer always ready.
        rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lat = 0;
            while (!o_rv && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("rr_id", o_id, k % 2);
            check("rr_res", {o_gt, o_eq, o_lt}, (k % 2) ? 3'b100 : 3'b001);
            @(posedge clk);
            #1;
        end
        v0 = 1'b0; v1 = 1'b0; rdy = 1'b0;

        run_op(1'b0, 8'h5A, 8'h5A, 3'b010, 9, "equal");
        run_op(1'b0, 8'h80, 8'h7F, 3'b100, 9, "uns_80_7f");
        run_op(1'b1, 8'hFF, 8'h01, 3'b100, 9, "uns_ff_01");
        dsel = 2'd1;
        run_op(1'b0, 8'h80, 8'h7F, 3'b001, 9, "sgn_80_7f");
        run_op(1'b0, 8'hFF, 8'h01, 3'b001, 9, "sgn_ff_01");
        run_op(1'b1, 8'h01, 8'hFF, 3'b100, 9, "sgn_01_ff");
        dsel = 2'd0;

        // Result backpressure with the other requester waiting.
        @(negedge clk);
        v0 = 1'b1; a0 = 8'h33; b0 = 8'h22;
        @(posedge clk);
        #1;
        v0 = 1'b0; v1 = 1'b1; a1 = 8'h44; b1 = 8'h44;
        lat = 0;
        while (!o_rv && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {o_rv, o_gt, o_eq, o_lt, o_id, o_r0, o_r1}, 7'b1100000);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy = 1'b0;
        check("bp_release", {o_rv, o_r0, o_r1}, 3'b001);
        v1 = 1'b0;

        // Reset while bit 3 is on the cell.
        @(negedge clk);
        v0 = 1'b1; a0 = 8'hF0; b0 = 8'h0F;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {o_r0, o_r1, o_rv, o_gt, o_eq, o_lt, o_id, o_ca, o_cb, o_ci}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (o_rv !== 1'b0) bad++;
        end
        check("rst_no_res", bad, 0);
        run_op(1'b0, 8'hF0, 8'h0F, 3'b100, 9, "after_rst");

        // Settle timing.
        dsel = 2'd2;
        run_op(1'b0, 8'h01, 8'h02, 3'b001, 25, "settle_01_02");
        run_op(1'b1, 8'h02, 8'h01, 3'b100, 25, "settle_02_01");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
